// File: rtl/gpc_pkg.sv
// Shared definitions for the (1,5;3) generalized parallel counter family:
// operand widths, a full-adder helper and a golden arithmetic reference.
package gpc_pkg;

  localparam int GPC_15_3_IN0_W = 5;  // weight-1 input bits (column i)
  localparam int GPC_15_3_IN1_W = 1;  // weight-2 input bits (column i+1)
  localparam int GPC_15_3_OUT_W = 3;  // binary sum, 0..7

  // Result of a single 3:2 compression: sum bit keeps the column weight,
  // carry bit moves one column up.
  typedef struct packed {
    logic carry;
    logic sum;
  } fa_t;

  // One full adder: three bits of equal weight in, sum and carry out.
  function automatic fa_t full_add(input logic a, input logic b, input logic c);
    fa_t r;
    r.sum   = a ^ b ^ c;
    r.carry = (a & b) | (a & c) | (b & c);
    return r;
  endfunction

  // Golden sum computed arithmetically rather than from the adder network,
  // so it can serve as an independent reference.
  function automatic logic [GPC_15_3_OUT_W-1:0] gpc_15_3_ref(
    input logic [GPC_15_3_IN0_W-1:0] src0,
    input logic [GPC_15_3_IN1_W-1:0] src1
  );
    logic [GPC_15_3_OUT_W-1:0] total;
    total = GPC_15_3_OUT_W'({src1, 1'b0});
    for (int i = 0; i < GPC_15_3_IN0_W; i++) begin
      total = total + GPC_15_3_OUT_W'(src0[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/gpc_15_3_core.sv
// Combinational (1,5;3) counter core: three full adders reduce five
// weight-1 bits and one weight-2 bit to a 3-bit binary sum.
module gpc_15_3_core
  import gpc_pkg::*;
(
  input  logic [GPC_15_3_IN0_W-1:0] src0,
  input  logic [GPC_15_3_IN1_W-1:0] src1,
  output logic [GPC_15_3_OUT_W-1:0] sum
);

  fa_t fa_a;  // first three weight-1 bits
  fa_t fa_b;  // remaining two weight-1 bits plus fa_a's sum
  fa_t fa_c;  // both weight-2 carries plus the weight-2 input

  assign fa_a = full_add(src0[0], src0[1], src0[2]);
  assign fa_b = full_add(src0[3], src0[4], fa_a.sum);
  assign fa_c = full_add(fa_a.carry, fa_b.carry, src1[0]);

  // Weight-1 bit from fa_b, weight-2 from fa_c's sum, weight-4 from its carry.
  // The maximum of 5 + 2 = 7 fits exactly, so no further carry exists.
  assign sum = {fa_c.carry, fa_c.sum, fa_b.sum};

endmodule

// File: rtl/gpc_15_3.sv
// Top of the (1,5;3) counter: wraps the combinational core with an
// optional one-cycle output register for dst and out_valid.
module gpc_15_3
  import gpc_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [GPC_15_3_IN0_W-1:0] src0,
  input  logic [GPC_15_3_IN1_W-1:0] src1,
  output logic                      out_valid,
  output logic [GPC_15_3_OUT_W-1:0] dst
);

  logic [GPC_15_3_OUT_W-1:0] sum;

  gpc_15_3_core u_core (
    .src0 (src0),
    .src1 (src1),
    .sum  (sum)
  );

  if (REG_OUT) begin : g_reg
    // Capture the sum every cycle and delay in_valid alongside it; dst needs
    // no enable because consumers qualify it with out_valid.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the register stage behaves identically regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dst       <= '0;
        out_valid <= 1'b0;
      end else begin
        dst       <= sum;
        out_valid <= in_valid;
      end
    end
  end else begin : g_comb
    assign dst       = sum;
    assign out_valid = in_valid;

    // No state in this configuration; clk and rst are deliberately unused.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end

endmodule

// File: tb/tb_gpc_15_3.sv
// Self-checking bench for gpc_15_3: registered instance checked through a
// scoreboard queue and monitor, combinational instance checked at drive time.
module tb_gpc_15_3;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [4:0] src0;
  logic [0:0] src1;
  logic       reg_out_valid;
  logic [2:0] reg_dst;
  logic       comb_out_valid;
  logic [2:0] comb_dst;

  typedef struct {
    logic       valid;
    logic [2:0] sum;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  gpc_15_3 #(.REG_OUT(1'b1)) dut_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .src0      (src0),
    .src1      (src1),
    .out_valid (reg_out_valid),
    .dst       (reg_dst)
  );

  gpc_15_3 #(.REG_OUT(1'b0)) dut_comb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .src0      (src0),
    .src1      (src1),
    .out_valid (comb_out_valid),
    .dst       (comb_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count the ones in src0 and add two for src1.
  function automatic logic [2:0] model(input logic [4:0] a, input logic [0:0] b);
    int total;
    total = $countones(a) + 2 * int'(b);
    return 3'(total);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one operand between edges, check the combinational instance at
  // once, and queue the registered instance's expected response.
  task automatic drive(input logic v, input logic [4:0] a, input logic [0:0] b,
                       input string tag);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    src0     = a;
    src1     = b;
    e.valid  = v;
    e.sum    = model(a, b);
    e.tag    = tag;
    exp_q.push_back(e);
    #1;
    check({tag, "_comb_dst"}, comb_dst, e.sum);
    check({tag, "_comb_valid"}, comb_out_valid, v);
  endtask

  // Monitor: after each rising edge, the registered outputs must reflect the
  // operand queued before that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, "_dst"}, reg_dst, e.sum);
        check({e.tag, "_valid"}, reg_out_valid, e.valid);
      end
    end
  end

  typedef struct {
    logic [4:0] a;
    logic [0:0] b;
  } vec_t;

  initial begin
    vec_t directed[8];
    vec_t stream[4];

    directed = '{'{5'h10, 1'b0}, '{5'h0a, 1'b0}, '{5'h00, 1'b0},
                 '{5'h1d, 1'b0}, '{5'h08, 1'b1}, '{5'h1c, 1'b1},
                 '{5'h1f, 1'b1}, '{5'h0f, 1'b0}};
    stream   = '{'{5'h1a, 1'b0}, '{5'h1a, 1'b1}, '{5'h01, 1'b1}, '{5'h03, 1'b0}};

    rst      = 1'b1;
    in_valid = 1'b0;
    src0     = '0;
    src1     = '0;

    // Reset must clear the register before any clock edge has occurred.
    #1;
    check("reset_dst", reg_dst, 0);
    check("reset_valid", reg_out_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed values, each separated by an idle cycle.
    foreach (directed[i]) begin
      drive(1'b1, directed[i].a, directed[i].b, $sformatf("dir%0d", i));
      drive(1'b0, 5'h00, 1'b0, $sformatf("idle%0d", i));
    end

    // Back-to-back stream: 3, 5, 3, 2 on consecutive cycles.
    foreach (stream[i]) drive(1'b1, stream[i].a, stream[i].b, $sformatf("b2b%0d", i));

    // Asynchronous reset between edges while out_valid is high.
    drive(1'b1, 5'h1f, 1'b1, "pre_rst");
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_dst", reg_dst, 0);
    check("async_rst_valid", reg_out_valid, 0);
    @(posedge clk);
    #1;
    check("hold_rst_dst", reg_dst, 0);
    check("hold_rst_valid", reg_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'h15, 1'b1, "post_rst");

    // Exhaustive sweep of all operands with random in_valid.
    for (int i = 0; i < 64; i++) begin
      drive(1'($urandom_range(0, 1)), 5'(i), 1'(i >> 5), $sformatf("sweep%0d", i));
    end

    // Random back-to-back traffic.
    for (int i = 0; i < 100; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
